// File: rtl/reg_link_writer.sv
// reg_link_writer: host-side transmitter for the two-phase byte-serial
// register write link. Sends the low byte, drops data_part, sends the high
// byte, then raises data_part to commit. Optionally waits for the receiver's
// echo of each data_part edge before starting the hold count.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a request, data_part high, link data parked
// LO_SETUP | low byte and address driven, data_part still high
// LO_HOLD  | data_part low (low byte latched by receiver), holding
// HI_SETUP | high byte driven, data_part still low
// HI_HOLD  | data_part high (write committed by receiver), holding
module reg_link_writer #(
  parameter int ADDR_BITS      = 3,
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic [15:0]          in_data,
  input  logic                 echo_en,
  output logic [7:0]           data_out,
  output logic [ADDR_BITS-1:0] addr_out,
  output logic                 data_part_out,
  output logic                 echo_out,
  input  logic                 echo_in,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LO_SETUP = 3'd1,
    LO_HOLD  = 3'd2,
    HI_SETUP = 3'd3,
    HI_HOLD  = 3'd4
  } state_t;

  // Down-counters load N-1 and finish on the cycle they read zero.
  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [3:0]  phase_cnt;
  logic [7:0]  tmo_cnt;
  logic        hold_go;
  logic        echo_mode;
  logic [7:0]  hi_byte;
  logic        echo_meta;
  logic        echo_sync;
  logic        hold_run;
  logic        tmo_hit;

  // The echo line shadows data_part exactly; the receiver loops it back.
  assign echo_out = data_part_out;

  // Hold counting proceeds once the echo has matched (or timed out), or
  // immediately when echo acknowledgement is not in use.
  assign hold_run = !echo_mode || hold_go || (echo_sync == data_part_out);
  assign tmo_hit  = (tmo_cnt == 8'd0);

  // Two-flop synchroniser for the asynchronous echo return; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= 1'b1;
      echo_sync <= 1'b1;
    end else begin
      echo_meta <= echo_in;
      echo_sync <= echo_meta;
    end
  end

  // Link sequencer: all link and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      phase_cnt     <= 4'd0;
      tmo_cnt       <= 8'd0;
      hold_go       <= 1'b0;
      echo_mode     <= 1'b0;
      hi_byte       <= 8'd0;
      data_out      <= 8'd0;
      addr_out      <= '0;
      data_part_out <= 1'b1;
      in_ready      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          data_part_out <= 1'b1;
          if (in_valid && in_ready) begin
            state       <= LO_SETUP;
            phase_cnt   <= SETUP_LOAD;
            echo_mode   <= echo_en;
            hi_byte     <= in_data[15:8];
            data_out    <= in_data[7:0];
            addr_out    <= in_addr;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end

        LO_SETUP, HI_SETUP: begin
          if (phase_cnt == 4'd0) begin
            state         <= (state == LO_SETUP) ? LO_HOLD : HI_HOLD;
            phase_cnt     <= HOLD_LOAD;
            tmo_cnt       <= TMO_LOAD;
            hold_go       <= 1'b0;
            data_part_out <= (state == HI_SETUP);
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end

        LO_HOLD, HI_HOLD: begin
          if (hold_run) begin
            hold_go <= 1'b1;
            if (phase_cnt == 4'd0) begin
              if (state == LO_HOLD) begin
                state     <= HI_SETUP;
                phase_cnt <= SETUP_LOAD;
                data_out  <= hi_byte;
              end else begin
                state    <= IDLE;
                in_ready <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt - 4'd1;
            end
          end else if (tmo_hit) begin
            // No abort on timeout: flag it and carry on so the word stays intact.
            timeout_err <= 1'b1;
            hold_go     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_link_writer.md
Name: reg_link_writer

Overview:
- Host-side transmitter for the two-phase byte-serial register write link that the delta-sigma DAC top level receives on data_in[7:0], addr[2:0] and data_part.
- Takes a 16-bit word plus register address over a valid/ready handshake and serialises it on the link:
  - low byte, then a data_part falling edge;
  - high byte, then a data_part rising edge, which commits the write.
- Optionally uses the receiver's echo loopback as per-edge acknowledgement.
- Used on the FPGA/RP2040-side bridge and as the stimulus driver in system benches.

Parameters:
ADDR_BITS, 3, width of register address
SETUP_CYCLES, 2, cycles data/addr are stable before each data_part edge (1..15)
HOLD_CYCLES, 4, cycles data/addr are held after each data_part edge (1..15; after echo match when echo mode is active)
TIMEOUT_CYCLES, 255, maximum cycles to wait for echo match (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  write request valid
in_ready  out  1  block can accept a request
in_addr  in  ADDR_BITS  target register address
in_data  in  16  word to write
echo_en  in  1  use echo acknowledgement for this request (sampled on accept)
data_out  out  8  link data byte (to receiver data_in)
addr_out  out  ADDR_BITS  link address (to receiver addr)
data_part_out  out  1  link phase strobe, idles high
echo_out  out  1  to receiver echo_in; always equals data_part_out
echo_in  in  1  from receiver echo output; asynchronous, synchronised internally
busy  out  1  transfer in progress (equals !in_ready)
done  out  1  one-cycle pulse when the word has been committed
timeout_err  out  1  sticky: echo not matched within TIMEOUT_CYCLES during the last transfer

Behaviour:
- All outputs are registered.
- Reset values:
  - data_out=0, addr_out=0
  - data_part_out=1, echo_out=1
  - in_ready=1, busy=0, done=0, timeout_err=0
  - state IDLE
- State machine: IDLE, LO_SETUP, LO_HOLD, HI_SETUP, HI_HOLD. One 4-bit phase counter, one 8-bit timeout counter.
- Accept occurs in cycle T when in_valid && in_ready.
  - Latch in_data, in_addr and echo_en.
  - Clear timeout_err.
  - in_ready drops at T+1.
- LO_SETUP:
  - From T+1: data_out=in_data[7:0], addr_out=in_addr, data_part_out=1.
  - Lasts SETUP_CYCLES cycles.
- LO_HOLD:
  - data_part_out=0; data_out and addr_out unchanged.
  - Lasts HOLD_CYCLES cycles.
- HI_SETUP:
  - data_out=in_data[15:8], data_part_out stays 0.
  - Lasts SETUP_CYCLES cycles.
- HI_HOLD:
  - data_part_out=1.
  - Lasts HOLD_CYCLES cycles.
- Return to IDLE:
  - done=1 and in_ready=1 in the cycle after the last HI_HOLD cycle.
  - Total accept-to-done is 2*(SETUP_CYCLES+HOLD_CYCLES)+1 cycles.
- Echo mode (latched echo_en=1):
  - echo_in passes through a 2-FF synchroniser.
  - In each HOLD state, the hold counter only starts counting once the synchronised echo equals data_part_out.
  - The timeout counter runs from entry into the HOLD state.
  - If it reaches TIMEOUT_CYCLES without a match, set timeout_err and start the hold count anyway. There is no abort, so the word is never corrupted by the writer.
- Echo mode off: echo_in is ignored and hold timing is fixed.
- IDLE:
  - data_out and addr_out keep their last values.
  - data_part_out=1.
- Back-to-back: a new accept may occur in the done cycle; LO_SETUP then starts the next cycle.
- in_valid while busy is ignored. Requests are not queued.
- Reset mid-transfer:
  - All outputs return to reset values at the next edge.
  - If reset hits during LO_HOLD or HI_SETUP, data_part_out rises. The receiver will then commit {0x00, low byte} to the latched address.
  - This is a known hazard; the system asserts link reset together with DAC reset.

Test Plan:
1. SETUP=2, HOLD=4, echo off; write addr=1 data=0x1234 accepted at T -> data_out=0x34 and addr_out=1 at T+1..T+6; data_part_out=0 at T+3..T+8; data_out=0x12 at T+7; data_part_out=1 at T+9; done at T+13 only. The receiver model's register 1 reads 0x1234.
2. Back-to-back: in_valid held with addr 0 data 0x8000, then addr 2 data 0xC3A5 -> second accept in first done cycle; both registers correct; in_ready low for exactly 12 cycles per word.
3. Echo mode with echo_in looped through a 5-cycle delay -> each HOLD phase stretches by the loop latency (5 cycles delay + 2 sync); done at T+13+2*(5+2); timeout_err stays 0.
4. Echo mode, echo_in stuck at 1 -> LO_HOLD waits 255 cycles, then timeout_err=1. Transfer still completes; done is asserted; timeout_err clears on the next accept.
5. Reset asserted during HI_SETUP of write 0xABCD -> next cycle data_part_out=1, data_out=0, in_ready=1, done=0. Receiver model commits 0x00CD (documented hazard).
6. in_valid pulsed during HI_HOLD with different data -> ignored; only the first word is written; no extra done.
